// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: one request in flight, fixed access delay,
// single-cycle ack with registered read data, out-of-range and collision flags.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              MemRW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              collision
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                rw_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                ack_reg;
    logic                err_reg;
    logic                collision_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                accept;
    logic                in_range;
    logic                in_access;
    logic [IDX_W-1:0]    mem_idx;

    assign ready     = (state_reg == S_IDLE) || (state_reg == S_RESP);
    assign accept    = ready && req;
    assign in_access = (state_reg == S_ACCESS);
    assign in_range  = ({1'b0, addr_reg} < DEPTH_L);
    assign mem_idx   = addr_reg[IDX_W-1:0];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE, S_RESP: begin
                if (req) begin
                    state_next = (WAIT_L != 4'd0) ? S_WAIT : S_ACCESS;
                    cnt_next   = WAIT_L;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_RESP;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control, request capture and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 4'd0;
            rw_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            collision_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            if (accept) begin
                rw_reg    <= MemRW;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            ack_reg       <= in_access;
            err_reg       <= in_access && !in_range;
            collision_reg <= req && !ready;
            // Writes leave rdata untouched; out-of-range reads return zero.
            if (in_access && !rw_reg) begin
                rdata_reg <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (in_access && rw_reg && in_range) begin
            mem[mem_idx] <= wdata_reg;
        end
    end

    assign ack       = ack_reg;
    assign err       = err_reg;
    assign collision = collision_reg;
    assign rdata     = rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with a 2-cycle delay and 1000 words,
// one with zero delay for back-to-back streaming.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, mem_rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        ready, ack, err, collision;
    logic [31:0] rdata;

    logic        req0, mem_rw0;
    logic [9:0]  addr0;
    logic [31:0] wdata0;
    logic        ready0, ack0, err0, collision0;
    logic [31:0] rdata0;

    int n_cmp = 0;
    int n_err = 0;

    int          lat;
    logic [31:0] rd;
    logic        e;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1000), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .MemRW(mem_rw), .addr(addr), .wdata(wdata),
        .ready(ready), .ack(ack), .rdata(rdata), .err(err), .collision(collision)
    );

    dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .MemRW(mem_rw0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0), .collision(collision0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Issue one request from IDLE/RESP and wait (bounded) for its ack; lat counts edges from acceptance.
    task automatic xact(input logic rw, input logic [9:0] a, input logic [31:0] d,
                        output int l, output logic [31:0] r, output logic ef);
        req = 1'b1; mem_rw = rw; addr = a; wdata = d;
        step();
        req = 1'b0;
        l = 1;
        while (ack !== 1'b1 && l < 20) begin
            step();
            l++;
        end
        r  = rdata;
        ef = err;
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0; mem_rw = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; mem_rw0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (2) step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_coll", 32'(collision), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready0", 32'(ready0), 32'd1);
        reset = 1'b0;
        step();

        // Write 0xDEADBEEF to addr 5
        req = 1'b1; mem_rw = 1'b1; addr = 10'd5; wdata = 32'hDEADBEEF;
        step();
        req = 1'b0;
        check("wr_ready_c1", 32'(ready), 32'd0);
        check("wr_ack_c1", 32'(ack), 32'd0);
        step();
        check("wr_ready_c2", 32'(ready), 32'd0);
        step();
        check("wr_ready_c3", 32'(ready), 32'd0);
        check("wr_ack_c3", 32'(ack), 32'd0);
        step();
        check("wr_ack_c4", 32'(ack), 32'd1);
        check("wr_ready_c4", 32'(ready), 32'd1);
        check("wr_err", 32'(err), 32'd0);
        check("wr_rdata", rdata, 32'h0);

        // Back-to-back read of addr 5, issued in the RESP cycle
        req = 1'b1; mem_rw = 1'b0; addr = 10'd5;
        step();
        req = 1'b0;
        check("b2b_ready_c1", 32'(ready), 32'd0);
        check("b2b_ack_c1", 32'(ack), 32'd0);
        step();
        step();
        check("b2b_ack_c3", 32'(ack), 32'd0);
        step();
        check("b2b_ack_c4", 32'(ack), 32'd1);
        check("b2b_rdata", rdata, 32'hDEADBEEF);
        check("b2b_err", 32'(err), 32'd0);
        step();
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_rdata_hold", rdata, 32'hDEADBEEF);

        // Out-of-range boundary at DEPTH=1000
        xact(1'b1, 10'd999, 32'h0999_0999, lat, rd, e);
        check("w999_lat", 32'(lat), 32'd4);
        check("w999_err", 32'(e), 32'd0);
        step();
        xact(1'b1, 10'd1000, 32'h0000_1234, lat, rd, e);
        check("w1000_lat", 32'(lat), 32'd4);
        check("w1000_err", 32'(e), 32'd1);
        step();
        check("err_clear", 32'(err), 32'd0);
        xact(1'b0, 10'd1000, 32'h0, lat, rd, e);
        check("r1000_err", 32'(e), 32'd1);
        check("r1000_rdata", rd, 32'h0);
        step();
        xact(1'b0, 10'd999, 32'h0, lat, rd, e);
        check("r999_err", 32'(e), 32'd0);
        check("r999_rdata", rd, 32'h0999_0999);
        step();

        // Collision during WAIT of a read to addr 5
        req = 1'b1; mem_rw = 1'b0; addr = 10'd5;
        step();
        req = 1'b0;
        check("col_pre", 32'(collision), 32'd0);
        step();
        req = 1'b1; mem_rw = 1'b1; addr = 10'd5; wdata = 32'hBAD0BAD0;
        step();
        req = 1'b0;
        check("col_pulse", 32'(collision), 32'd1);
        check("col_ack_early", 32'(ack), 32'd0);
        step();
        check("col_post", 32'(collision), 32'd0);
        check("col_ack", 32'(ack), 32'd1);
        check("col_rdata", rdata, 32'hDEADBEEF);
        step();
        check("col_no_ack1", 32'(ack), 32'd0);
        step();
        check("col_no_ack2", 32'(ack), 32'd0);
        check("col_ready", 32'(ready), 32'd1);

        // Reset during WAIT of a write to addr 7
        xact(1'b1, 10'd7, 32'h0000_0055, lat, rd, e);
        check("w7_lat", 32'(lat), 32'd4);
        step();
        req = 1'b1; mem_rw = 1'b1; addr = 10'd7; wdata = 32'h0000_00AA;
        step();
        req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ack0", 32'(ack), 32'd0);
        step();
        check("abort_ack1", 32'(ack), 32'd0);
        step();
        check("abort_ack2", 32'(ack), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        reset = 1'b0;
        step();
        check("abort_ack3", 32'(ack), 32'd0);
        check("abort_ready2", 32'(ready), 32'd1);
        xact(1'b0, 10'd7, 32'h0, lat, rd, e);
        check("r7_rdata", rd, 32'h0000_0055);
        check("r7_lat", 32'(lat), 32'd4);
        step();

        // Zero-delay instance, req held high: write A, read, write B, read on addr 3
        req0 = 1'b1; mem_rw0 = 1'b1; addr0 = 10'd3; wdata0 = 32'hA5A5_0001;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("s_ack_%0d", k), 32'(ack0), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("s_ready_%0d", k), 32'(ready0), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("s_coll_%0d", k), 32'(collision0), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 1) check("s_wr_rdata0", rdata0, 32'h0);
            if (k == 3) check("s_rd_a", rdata0, 32'hA5A5_0001);
            if (k == 5) check("s_wr_keep", rdata0, 32'hA5A5_0001);
            if (k == 7) check("s_rd_b", rdata0, 32'h5A5A_0002);
            if (k % 2 == 1) check($sformatf("s_err_%0d", k), 32'(err0), 32'd0);
            case (k)
                1: mem_rw0 = 1'b0;
                3: begin mem_rw0 = 1'b1; wdata0 = 32'h5A5A_0002; end
                5: mem_rw0 = 1'b0;
                7: req0 = 1'b0;
                default: ;
            endcase
        end
        step();
        check("s_idle_ack", 32'(ack0), 32'd0);
        check("s_idle_ready", 32'(ready0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
